// File: rtl/add_share_arb.sv
// Round-robin arbiter that time-shares one external combinational adder among
// NREQ requesters and returns each {cout,sum} result, tagged with its ID, on one valid/ready port.
module add_share_arb #(
  parameter int NREQ = 4,
  parameter int W    = 32,
  parameter int IDW  = 2,
  parameter int CNTW = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [W-1:0]      add_a,
  output logic [W-1:0]      add_b,
  input  logic [W:0]        add_res,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [W:0]        res_data,
  output logic [IDW-1:0]    res_id,
  output logic [CNTW-1:0]   done_cnt
);

  logic            res_valid_q, res_valid_d;
  logic [W:0]      res_data_q, res_data_d;
  logic [IDW-1:0]  res_id_q, res_id_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [CNTW-1:0] done_cnt_q, done_cnt_d;

  logic            can_accept;
  logic            grant_vld;
  logic [IDW-1:0]  grant_id;
  logic            drain;
  int              idx;

  // Gating with rst_n keeps req_ready low for the whole time reset is held.
  assign can_accept = rst_n & (~res_valid_q | res_ready);
  assign drain      = res_valid_q & res_ready;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    idx       = 0;
    if (can_accept) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = int'(ptr_q) + k;
        if (idx >= NREQ) idx = idx - NREQ;
        if (!grant_vld && req_valid[idx]) begin
          grant_vld = 1'b1;
          grant_id  = IDW'(idx);
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    add_a     = '0;
    add_b     = '0;
    if (grant_vld) begin
      req_ready[grant_id] = 1'b1;
      add_a = req_a[int'(grant_id)*W +: W];
      add_b = req_b[int'(grant_id)*W +: W];
    end
  end

  always_comb begin
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_id_d    = res_id_q;
    ptr_d       = ptr_q;
    done_cnt_d  = done_cnt_q;
    if (drain) begin
      res_valid_d = 1'b0;
      done_cnt_d  = done_cnt_q + 1'b1;
    end
    // A grant in the same cycle as a drain refills the slot: no bubble.
    if (grant_vld) begin
      res_valid_d = 1'b1;
      res_data_d  = add_res;
      res_id_d    = grant_id;
      ptr_d       = (int'(grant_id) == NREQ-1) ? '0 : IDW'(int'(grant_id) + 1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= '0;
      ptr_q       <= '0;
      done_cnt_q  <= '0;
    end else begin
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_id_q    <= res_id_d;
      ptr_q       <= ptr_d;
      done_cnt_q  <= done_cnt_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;
  assign done_cnt  = done_cnt_q;

endmodule

// File: tb/tb_add_share_arb.sv
// Scoreboard bench for add_share_arb with an exact-adder stub; a reference
// round-robin model predicts grants and pushes expected results for the monitor.
module tb_add_share_arb;

  localparam int NREQ = 4;
  localparam int W    = 32;
  localparam int IDW  = 2;
  localparam int CNTW = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid, req_ready;
  logic [NREQ*W-1:0] req_a, req_b;
  logic [W-1:0]      add_a, add_b;
  logic [W:0]        add_res;
  logic              res_valid, res_ready;
  logic [W:0]        res_data;
  logic [IDW-1:0]    res_id;
  logic [CNTW-1:0]   done_cnt;

  typedef struct {
    logic [IDW-1:0] id;
    logic [W:0]     data;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  int   m_ptr;
  bit   m_valid;
  int   m_done;
  int   accepts;

  always #5 clk = ~clk;

  assign add_res = {1'b0, add_a} + {1'b0, add_b};

  add_share_arb #(.NREQ(NREQ), .W(W), .IDW(IDW), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .add_a(add_a), .add_b(add_b), .add_res(add_res),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_id(res_id), .done_cnt(done_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every output handshake pops and compares the oldest expected result.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 64'(res_data), 64'hDEAD);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("res_data", 64'(res_data), 64'(e.data));
          check("res_id", 64'(res_id), 64'(e.id));
        end
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    exp_q.delete();
    m_ptr = 0; m_valid = 0; m_done = 0; accepts = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Drive one cycle (called at posedge+1); checks grant and advances the model.
  task automatic cycle(input logic [NREQ-1:0] v, input logic [NREQ*W-1:0] a,
                       input logic [NREQ*W-1:0] b, input logic rdy);
    int g;
    logic [NREQ-1:0] exp_rdy;
    exp_t e;
    req_valid = v; req_a = a; req_b = b; res_ready = rdy;
    #3;
    g = -1;
    if (!m_valid || rdy) begin
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (m_ptr + k) % NREQ;
        if (g < 0 && v[i]) g = i;
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    check("req_ready", 64'(req_ready), 64'(exp_rdy));
    check("res_valid", 64'(res_valid), 64'(m_valid));
    if (m_valid && !rdy && exp_q.size() > 0) begin
      check("stall_data", 64'(res_data), 64'(exp_q[0].data));
      check("stall_id", 64'(res_id), 64'(exp_q[0].id));
    end
    if (g >= 0) begin
      e.id   = IDW'(g);
      e.data = {1'b0, a[g*W +: W]} + {1'b0, b[g*W +: W]};
      exp_q.push_back(e);
    end
    @(posedge clk);
    if (m_valid && rdy) m_done++;
    if (g >= 0) begin
      m_valid = 1; m_ptr = (g + 1) % NREQ; accepts++;
    end else if (rdy) begin
      m_valid = 0;
    end
    #1;
  endtask

  function automatic logic [NREQ*W-1:0] lanes(input logic [W-1:0] base);
    logic [NREQ*W-1:0] r;
    for (int i = 0; i < NREQ; i++) r[i*W +: W] = base + W'(i * 16'h1111);
    return r;
  endfunction

  initial begin
    logic [NREQ*W-1:0] ra, rb;
    int budget;
    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; res_ready = 1'b0;
    #2;
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_res_data", 64'(res_data), 64'd0);
    check("rst_res_id", 64'(res_id), 64'd0);
    check("rst_done_cnt", 64'(done_cnt), 64'd0);
    req_valid = 4'b1111;
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd0);
    do_reset();

    // Single request with carry out.
    ra = '0; rb = '0;
    ra[W-1:0] = 32'hFFFF_FFFF; rb[W-1:0] = 32'h1;
    req_valid = 4'b0001; res_ready = 1'b1; #1;
    check("t1_req_ready", 64'(req_ready), 64'h1);
    #1;
    cycle(4'b0001, ra, rb, 1'b1);
    check("t1_res_data", 64'(res_data), 64'h1_0000_0000);
    check("t1_res_id", 64'(res_id), 64'd0);
    cycle(4'b0000, '0, '0, 1'b1);
    check("t1_done_cnt", 64'(done_cnt), 64'd1);

    // All four continuously valid: 0,1,2,3,0,1,2,3.
    do_reset();
    for (int n = 0; n < 8; n++) cycle(4'b1111, lanes(32'h100 * n), lanes(32'h7), 1'b1);
    cycle(4'b0000, '0, '0, 1'b1);
    check("t2_done_cnt", 64'(done_cnt), 64'd8);

    // Backpressure: 5 stall cycles, then release with no bubble.
    do_reset();
    cycle(4'b1111, lanes(32'hA000_0000), lanes(32'h6000_0000), 1'b0);
    for (int n = 0; n < 5; n++) cycle(4'b1111, lanes(32'h5), lanes(32'h9), 1'b0);
    check("t3_stall_id", 64'(res_id), 64'd0);
    cycle(4'b1111, lanes(32'h10), lanes(32'h20), 1'b1);
    check("t3_release_valid", 64'(res_valid), 64'd1);
    check("t3_release_id", 64'(res_id), 64'd1);
    cycle(4'b0000, '0, '0, 1'b1);

    // Sparse round robin: reach ptr=3, then 0110 -> 1, then 0011 -> 0.
    do_reset();
    cycle(4'b0100, lanes(32'h1), lanes(32'h2), 1'b1);
    req_valid = 4'b0110; #1;
    check("t4_grant1", 64'(req_ready), 64'b0010);
    #1;
    cycle(4'b0110, lanes(32'h3), lanes(32'h4), 1'b1);
    req_valid = 4'b0011; #1;
    check("t4_grant0", 64'(req_ready), 64'b0001);
    #1;
    cycle(4'b0011, lanes(32'h5), lanes(32'h6), 1'b1);
    cycle(4'b0000, '0, '0, 1'b1);
    check("t4_done_cnt", 64'(done_cnt), 64'd3);

    // Asynchronous reset mid-stream while a result is held.
    cycle(4'b1111, lanes(32'h77), lanes(32'h88), 1'b0);
    req_valid = 4'b1111; res_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_res_valid", 64'(res_valid), 64'd0);
    check("t5_done_cnt", 64'(done_cnt), 64'd0);
    check("t5_req_ready", 64'(req_ready), 64'd0);
    exp_q.delete();
    m_ptr = 0; m_valid = 0; m_done = 0; accepts = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    req_valid = 4'b1111; #1;
    check("t5_after_release", 64'(req_ready), 64'b0001);
    #1;

    // Random traffic: 1000 accepted operations.
    do_reset();
    budget = 0;
    while (accepts < 1000 && budget < 5000) begin
      for (int i = 0; i < NREQ; i++) begin
        ra[i*W +: W] = $urandom;
        rb[i*W +: W] = $urandom;
      end
      cycle(NREQ'($urandom_range(0, 15)), ra, rb, 1'($urandom_range(0, 3) != 0));
      budget++;
    end
    check("t6_accepts", 64'(accepts), 64'd1000);
    budget = 0;
    while (m_valid && budget < 20) begin
      cycle(4'b0000, '0, '0, 1'b1);
      budget++;
    end
    check("t6_done_cnt", 64'(done_cnt), 64'd1000);
    check("t6_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
